// File: rtl/dst_serializer_pkg.sv
// Shared types and sizing helpers for the dst column serializer.
// Optional parity beat is enabled with DST_SERIALIZER_PARITY_EN.
package dst_ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int unsigned DEF_NUM_COLS = 32'd43;
  localparam int unsigned DEF_COL_W    = 32'd1;

  function automatic int unsigned total_bits(input int unsigned num_cols,
                                             input int unsigned col_w);
    return num_cols * col_w;
  endfunction

  // Counter must hold TOTAL itself after the final shift.
  function automatic int unsigned cnt_width(input int unsigned total);
    return $clog2(total + 32'd1);
  endfunction

endpackage

// File: rtl/dst_serializer_if.sv
// Load/serial handshake bundle between the harness (master) and the serializer (slave).
interface dst_serializer_if #(
  parameter int unsigned NUM_COLS = 32'd43,
  parameter int unsigned COL_W    = 32'd1
);
  logic                        load_valid;
  logic                        load_ready;
  logic [NUM_COLS*COL_W-1:0]   dst_vec;
  logic                        sout;
  logic                        sout_valid;
  logic                        sout_ready;
  logic                        sout_last;
  logic                        busy;

  modport master (
    output load_valid, dst_vec, sout_ready,
    input  load_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  load_valid, dst_vec, sout_ready,
    output load_ready, sout, sout_valid, sout_last, busy
  );
endinterface

// File: rtl/dst_serializer.sv
// Captures the parallel dst columns and shifts them out LSB first, one bit per handshake.
// Define DST_SERIALIZER_PARITY_EN to append an even-parity beat to every frame.
module dst_serializer #(
  parameter int unsigned NUM_COLS = 32'd43,
  parameter int unsigned COL_W    = 32'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  dst_serializer_if.slave  bus
);
  import dst_ser_pkg::*;

  localparam int unsigned       TOTAL    = total_bits(NUM_COLS, COL_W);
  localparam int unsigned       CNT_W    = cnt_width(TOTAL);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TOTAL - 32'd1);

  state_e              state_r;
  state_e              state_s;
  logic [TOTAL-1:0]    sreg_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                load_ready_s;
  logic                sout_s;
  logic                sout_valid_s;
  logic                sout_last_s;
`ifdef DST_SERIALIZER_PARITY_EN
  logic                par_r;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; the last data beat leaves SHIFT only on acceptance.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.load_valid) state_s = SHIFT;
        else                state_s = IDLE;
      end
      SHIFT: begin
        if (bus.sout_ready && (cnt_r == LAST_CNT)) begin
`ifdef DST_SERIALIZER_PARITY_EN
          state_s = PARITY;
`else
          state_s = IDLE;
`endif
        end else begin
          state_s = SHIFT;
        end
      end
`ifdef DST_SERIALIZER_PARITY_EN
      PARITY: begin
        if (bus.sout_ready) state_s = IDLE;
        else                state_s = PARITY;
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // Shift register, beat counter and running parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_r <= '0;
      cnt_r  <= '0;
`ifdef DST_SERIALIZER_PARITY_EN
      par_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.load_valid) begin
            sreg_r <= bus.dst_vec;
            cnt_r  <= '0;
`ifdef DST_SERIALIZER_PARITY_EN
            par_r  <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (bus.sout_ready) begin
            sreg_r <= sreg_r >> 1;
            cnt_r  <= cnt_r + CNT_W'(1);
`ifdef DST_SERIALIZER_PARITY_EN
            par_r  <= par_r ^ sreg_r[0];
`endif
          end
        end
        default: begin
          sreg_r <= sreg_r;
          cnt_r  <= cnt_r;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only; sout_ready never reaches them.
  always_comb begin
    load_ready_s = 1'b0;
    sout_s       = 1'b0;
    sout_valid_s = 1'b0;
    sout_last_s  = 1'b0;
    case (state_r)
      IDLE: begin
        load_ready_s = 1'b1;
      end
      SHIFT: begin
        sout_valid_s = 1'b1;
        sout_s       = sreg_r[0];
`ifdef DST_SERIALIZER_PARITY_EN
        sout_last_s  = 1'b0;
`else
        sout_last_s  = (cnt_r == LAST_CNT);
`endif
      end
`ifdef DST_SERIALIZER_PARITY_EN
      PARITY: begin
        sout_valid_s = 1'b1;
        sout_s       = par_r;
        sout_last_s  = 1'b1;
      end
`endif
      default: begin
        load_ready_s = 1'b0;
      end
    endcase
  end

  assign bus.load_ready = load_ready_s;
  assign bus.busy       = ~load_ready_s;
  assign bus.sout       = sout_s;
  assign bus.sout_valid = sout_valid_s;
  assign bus.sout_last  = sout_last_s;

endmodule

// File: tb/tb_dst_serializer.sv
// Self-checking bench for dst_serializer: vector table, corner sequences, random frames.
module tb_dst_serializer;

  localparam int NUM_COLS = 43;
  localparam int COL_W    = 1;
  localparam int TOTAL    = NUM_COLS * COL_W;
`ifdef DST_SERIALIZER_PARITY_EN
  localparam int FRAME    = TOTAL + 1;
`else
  localparam int FRAME    = TOTAL;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
`ifdef DST_SERIALIZER_PARITY_EN
  logic par_obs;
`endif

  dst_serializer_if #(.NUM_COLS(NUM_COLS), .COL_W(COL_W)) bus ();

  dst_serializer #(.NUM_COLS(NUM_COLS), .COL_W(COL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TOTAL-1:0] vec;
    int               mode;     // 0 always ready, 1 toggling ready, 2 random ready
    logic             exp_par;  // hand-computed even parity of vec
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: data bits LSB first, then optional even parity of all data bits.
  function automatic logic exp_bit(input logic [TOTAL-1:0] v, input int k);
    if (k < TOTAL) return v[k];
    return ^v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at a sample point with the DUT idle; leaves the first beat presented.
  task automatic load(input logic [TOTAL-1:0] v);
    chk("load_ready_idle", bus.load_ready, 1);
    bus.load_valid = 1'b1;
    bus.dst_vec    = v;
    tick();
    bus.load_valid = 1'b0;
    chk("first_valid", bus.sout_valid, 1);
  endtask

  task automatic recv_frame(input logic [TOTAL-1:0] v, input int mode, input int abort_at,
                            input logic [TOTAL-1:0] poke_vec, input int poke_at,
                            output logic [TOTAL-1:0] rx);
    int   beat;
    int   cyc;
    logic held;
    logic held_sout;
    logic rdy;
    logic tog;
    beat = 0; cyc = 0; held = 1'b0; held_sout = 1'b0; tog = 1'b1;
    rx = '0;
    while (beat < FRAME && cyc < 4000) begin
      if (abort_at >= 0 && beat == abort_at) break;
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = tog;
      else                rdy = 1'($urandom_range(0, 1));
      tog = ~tog;
      bus.sout_ready = rdy;
      if (poke_at >= 0) begin
        bus.load_valid = (beat == poke_at);
        if (beat == poke_at) bus.dst_vec = poke_vec;
      end
      chk("sout_valid", bus.sout_valid, 1);
      chk("busy_not_ready", bus.load_ready, 0);
      chk("busy", bus.busy, 1);
      if (held) chk("stall_hold", bus.sout, held_sout);
      if (rdy) begin
        chk("sout_bit", bus.sout, exp_bit(v, beat));
        chk("sout_last", bus.sout_last, (beat == FRAME - 1));
        if (beat < TOTAL) rx[beat] = bus.sout;
`ifdef DST_SERIALIZER_PARITY_EN
        else par_obs = bus.sout;
`endif
        beat++;
        held = 1'b0;
      end else begin
        held      = 1'b1;
        held_sout = bus.sout;
      end
      tick();
      cyc++;
    end
    if (poke_at >= 0) bus.load_valid = 1'b0;
    if (abort_at < 0) begin
      bus.sout_ready = 1'b0;
      chk("frame_timeout", beat, FRAME);
      chk("ready_after_last", bus.load_ready, 1);
      chk("valid_after_last", bus.sout_valid, 0);
    end
  endtask

  initial begin
    logic [TOTAL-1:0] rx;
    logic [63:0]      rnd;
    logic [TOTAL-1:0] v;
    int               m;
    n_chk = 0;
    n_fail = 0;
    tbl[0] = '{43'h1,            0, 1'b1};
    tbl[1] = '{43'h555_5555_5555, 1, 1'b0};
    tbl[2] = '{43'h7FF_FFFF_FFFF, 2, 1'b1};
    tbl[3] = '{43'h0,            0, 1'b0};
    tbl[4] = '{43'h7,            1, 1'b1};
    tbl[5] = '{43'h3,            2, 1'b0};

    rst_n          = 1'b0;
    bus.load_valid = 1'b0;
    bus.dst_vec    = '0;
    bus.sout_ready = 1'b0;
    tick();
    chk("rst_load_ready", bus.load_ready, 1);
    chk("rst_sout_valid", bus.sout_valid, 0);
    chk("rst_sout", bus.sout, 0);
    chk("rst_sout_last", bus.sout_last, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    tick();

    // Table of whole frames under different ready patterns.
    for (int i = 0; i < 6; i++) begin
      load(tbl[i].vec);
      recv_frame(tbl[i].vec, tbl[i].mode, -1, '0, -1, rx);
      chk("tbl_rx", rx, tbl[i].vec);
      chk("tbl_rx_parity", ^rx, tbl[i].exp_par);
`ifdef DST_SERIALIZER_PARITY_EN
      chk("tbl_parity_beat", par_obs, tbl[i].exp_par);
`endif
    end

    // load_valid pulsed mid-frame is ignored.
    load(43'h123_4567_89AB);
    recv_frame(43'h123_4567_89AB, 0, -1, 43'h7AB_CDEF_0123, 5, rx);
    chk("midload_ignored", rx, 43'h123_4567_89AB);
    load(43'h7AB_CDEF_0123);
    recv_frame(43'h7AB_CDEF_0123, 2, -1, '0, -1, rx);
    chk("midload_next", rx, 43'h7AB_CDEF_0123);

    // Asynchronous reset after ten beats, then a clean frame.
    load(43'h0F0_F0F0_F0F0);
    recv_frame(43'h0F0_F0F0_F0F0, 0, 10, '0, -1, rx);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sout_valid", bus.sout_valid, 0);
    chk("arst_load_ready", bus.load_ready, 1);
    chk("arst_sout", bus.sout, 0);
    chk("arst_sout_last", bus.sout_last, 0);
    chk("arst_busy", bus.busy, 0);
    bus.sout_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    load(43'h3C3_C3C3_C3C3);
    recv_frame(43'h3C3_C3C3_C3C3, 0, -1, '0, -1, rx);
    chk("post_rst_frame", rx, 43'h3C3_C3C3_C3C3);

    // Back-to-back loads with load_valid held: one idle cycle between frames.
    bus.load_valid = 1'b1;
    bus.dst_vec    = 43'h7FF_FFFF_FFFF;
    tick();
    bus.dst_vec    = 43'h0;
    chk("b2b_first_valid", bus.sout_valid, 1);
    recv_frame(43'h7FF_FFFF_FFFF, 0, -1, '0, -1, rx);
    chk("b2b_ones", rx, 43'h7FF_FFFF_FFFF);
    tick();
    bus.load_valid = 1'b0;
    chk("b2b_second_valid", bus.sout_valid, 1);
    chk("b2b_second_busy", bus.load_ready, 0);
    recv_frame(43'h0, 0, -1, '0, -1, rx);
    chk("b2b_zeros", rx, 43'h0);

    // Random vectors and ready patterns against the frame model.
    for (int i = 0; i < 20; i++) begin
      rnd = {$urandom, $urandom};
      v   = rnd[TOTAL-1:0];
      m   = int'($urandom_range(0, 2));
      load(v);
      recv_frame(v, m, -1, '0, -1, rx);
      chk("rand_rx", rx, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
